id_exe_reg: RTL

ID_EXE_REG -- requirements
Module: id_exe_reg

---
 rtl/id_exe_reg.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: loads decoded operands and control on each clock,
// holds them on freeze, and replaces the entry with a bubble on flush.
module id_exe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [11:0] shift_operand_in,
  input  logic        imm_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [3:0]  status_in,
  output logic [31:0] pc_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic [11:0] shift_operand_out,
  output logic        imm_out,
  output logic [23:0] signed_imm_24_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
  output logic [3:0]  exe_cmd_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        b_out,
  output logic        s_out,
  output logic [3:0]  status_out,
  output logic        valid_out,
  output logic        mem_rw_en_out,
  output logic [15:0] bubble_cnt
);

  logic [31:0] pc_q, pc_d, val_rn_q, val_rn_d, val_rm_q, val_rm_d;
  logic [11:0] shift_operand_q, shift_operand_d;
  logic        imm_q, imm_d;
  logic [23:0] signed_imm_24_q, signed_imm_24_d;
  logic [3:0]  dest_q, dest_d, src1_q, src1_d, src2_q, src2_d, exe_cmd_q, exe_cmd_d;
  logic        wb_en_q, wb_en_d, mem_r_en_q, mem_r_en_d, mem_w_en_q, mem_w_en_d;
  logic        b_q, b_d, s_q, s_d, valid_q, valid_d, mem_rw_en_q, mem_rw_en_d;
  logic [3:0]  status_q, status_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  logic load_data, load_ctrl, ctrl_en, bubble_inc;

  // Flush still captures the data fields; only identity and control are zeroed.
  assign load_data  = flush | ~freeze;
  assign load_ctrl  = ~flush & ~freeze;
  assign ctrl_en    = load_ctrl & id_valid;
  assign bubble_inc = flush | (~freeze & ~id_valid);

  always_comb begin
    pc_d            = pc_q;
    val_rn_d        = val_rn_q;
    val_rm_d        = val_rm_q;
    shift_operand_d = shift_operand_q;
    imm_d           = imm_q;
    signed_imm_24_d = signed_imm_24_q;
    status_d        = status_q;
    dest_d          = dest_q;
    src1_d          = src1_q;
    src2_d          = src2_q;
    exe_cmd_d       = exe_cmd_q;
    valid_d         = valid_q;
    wb_en_d         = wb_en_q;
    mem_r_en_d      = mem_r_en_q;
    mem_w_en_d      = mem_w_en_q;
    b_d             = b_q;
    s_d             = s_q;
    mem_rw_en_d     = mem_rw_en_q;
    bubble_cnt_d    = bubble_cnt_q;

    if (load_data) begin
      pc_d            = pc_in;
      val_rn_d        = val_rn_in;
      val_rm_d        = val_rm_in;
      shift_operand_d = shift_operand_in;
      imm_d           = imm_in;
      signed_imm_24_d = signed_imm_24_in;
      status_d        = status_in;
    end

    if (flush) begin
      dest_d      = 4'h0;
      src1_d      = 4'h0;
      src2_d      = 4'h0;
      exe_cmd_d   = 4'h0;
      valid_d     = 1'b0;
      wb_en_d     = 1'b0;
      mem_r_en_d  = 1'b0;
      mem_w_en_d  = 1'b0;
      b_d         = 1'b0;
      s_d         = 1'b0;
      mem_rw_en_d = 1'b0;
    end else if (load_ctrl) begin
      dest_d      = dest_in;
      src1_d      = src1_in;
      src2_d      = src2_in;
      exe_cmd_d   = exe_cmd_in;
      valid_d     = id_valid;
      wb_en_d     = ctrl_en & wb_en_in;
      mem_r_en_d  = ctrl_en & mem_r_en_in;
      mem_w_en_d  = ctrl_en & mem_w_en_in;
      b_d         = ctrl_en & b_in;
      s_d         = ctrl_en & s_in;
      mem_rw_en_d = ctrl_en & (mem_r_en_in | mem_w_en_in);
    end

    // Saturate rather than wrap so a long-running count stays meaningful.
    if (bubble_inc && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q            <= '0;
      val_rn_q        <= '0;
      val_rm_q        <= '0;
      shift_operand_q <= '0;
      imm_q           <= 1'b0;
      signed_imm_24_q <= '0;
      status_q        <= '0;
      dest_q          <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      exe_cmd_q       <= '0;
      valid_q         <= 1'b0;
      wb_en_q         <= 1'b0;
      mem_r_en_q      <= 1'b0;
      mem_w_en_q      <= 1'b0;
      b_q             <= 1'b0;
      s_q             <= 1'b0;
      mem_rw_en_q     <= 1'b0;
      bubble_cnt_q    <= '0;
    end else begin
      pc_q            <= pc_d;
      val_rn_q        <= val_rn_d;
      val_rm_q        <= val_rm_d;
      shift_operand_q <= shift_operand_d;
      imm_q           <= imm_d;
      signed_imm_24_q <= signed_imm_24_d;
      status_q        <= status_d;
      dest_q          <= dest_d;
      src1_q          <= src1_d;
      src2_q          <= src2_d;
      exe_cmd_q       <= exe_cmd_d;
      valid_q         <= valid_d;
      wb_en_q         <= wb_en_d;
      mem_r_en_q      <= mem_r_en_d;
      mem_w_en_q      <= mem_w_en_d;
      b_q             <= b_d;
      s_q             <= s_d;
      mem_rw_en_q     <= mem_rw_en_d;
      bubble_cnt_q    <= bubble_cnt_d;
    end
  end

  assign pc_out            = pc_q;
  assign val_rn_out        = val_rn_q;
  assign val_rm_out        = val_rm_q;
  assign shift_operand_out = shift_operand_q;
  assign imm_out           = imm_q;
  assign signed_imm_24_out = signed_imm_24_q;
  assign status_out        = status_q;
  assign dest_out          = dest_q;
  assign src1_out          = src1_q;
  assign src2_out          = src2_q;
  assign exe_cmd_out       = exe_cmd_q;
  assign valid_out         = valid_q;
  assign wb_en_out         = wb_en_q;
  assign mem_r_en_out      = mem_r_en_q;
  assign mem_w_en_out      = mem_w_en_q;
  assign b_out             = b_q;
  assign s_out             = s_q;
  assign mem_rw_en_out     = mem_rw_en_q;
  assign bubble_cnt        = bubble_cnt_q;

endmodule
